dk8ep_clock: RTL and testbench

Programmable real-time clock for the PDP-8/e core, successor to the fixed-rate DK8E line clock. Adds a loadable preset buffer, a readable up-counter of parametrised width, four counting modes, an overrun indicator and a parametrised IOT device code. It sits on the CPU IOT bus beside the other peripherals. It decodes IOTs in state F1, returns skip/AC data to the CPU and raises `interrupt` to the interrupt controller.

---
 rtl/pdp8_pkg.sv | 37 +++
 rtl/rtc_prescaler.sv | 28 ++
 rtl/dk8ep_clock.sv | 190 +++++++++++++++++++
 tb/tb_dk8ep_clock.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdp8_pkg.sv
// Shared PDP-8/e bus definitions: major-state codes, IOT field positions, CAF
// encoding, plus the mode and function codes used by the real-time clock.
package pdp8_pkg;

    localparam logic [4:0] ST_F0 = 5'd0;
    localparam logic [4:0] ST_F1 = 5'd1;

    // Instruction bits are numbered 0 (MSB) to 11 (LSB), as on the PDP-8.
    localparam int OP_MSB  = 0;
    localparam int OP_LSB  = 2;
    localparam int DEV_MSB = 3;
    localparam int DEV_LSB = 8;
    localparam int FN_MSB  = 9;
    localparam int FN_LSB  = 11;

    localparam logic [2:0]  OP_IOT   = 3'o6;
    localparam logic [11:0] CAF_INSN = 12'o6007;

    typedef enum logic [1:0] {
        MODE_STOP   = 2'd0,
        MODE_FREE   = 2'd1,
        MODE_RELOAD = 2'd2,
        MODE_SINGLE = 2'd3
    } rtc_mode_t;

    typedef enum logic [2:0] {
        FN_NOP  = 3'd0,
        FN_CLSK = 3'd1,
        FN_CLLB = 3'd2,
        FN_CLRC = 3'd3,
        FN_CLEI = 3'd4,
        FN_CLED = 3'd5,
        FN_CLMD = 3'd6,
        FN_CLRS = 3'd7
    } rtc_fn_t;

endpackage

// File: rtl/rtc_prescaler.sv
// Divides the system clock by CLK_DIV; tick is high for the one cycle in
// which the divider sits at its terminal count.
module rtc_prescaler #(
    parameter int CLK_DIV = 500000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int            CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (count_reg == TERM) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign tick = (count_reg == TERM);

endmodule

// File: rtl/dk8ep_clock.sv
// Programmable real-time clock on the PDP-8/e IOT bus: preset buffer, up-counter,
// four counting modes, overrun flag. Define DK8EP_EXT_TICK_EN to count ext_tick edges.
module dk8ep_clock
    import pdp8_pkg::*;
#(
    parameter int         CNT_W    = 12,
    parameter int         CLK_DIV  = 500000,
    parameter logic [5:0] DEV_CODE = 6'o13
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [0:11] instruction,
    input  logic [4:0]  state,
    input  logic        clear,
    input  logic        UF,
    input  logic [0:11] ac,
    input  logic        ext_tick,
    output logic [0:11] ac_out,
    output logic        ac_load,
    output logic        ac_clear,
    output logic        skip,
    output logic        interrupt
);

    logic tick;

`ifdef DK8EP_EXT_TICK_EN
    // Two synchroniser flops, third flop remembers the previous synchronised level.
    logic [2:0] ext_sync_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ext_sync_reg <= '0;
        end else begin
            ext_sync_reg <= {ext_sync_reg[1:0], ext_tick};
        end
    end

    assign tick = ext_sync_reg[1] & ~ext_sync_reg[2];
`else
    logic unused_ext_tick;
    assign unused_ext_tick = ext_tick;

    rtc_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );
`endif

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] buffer_reg;
    logic [CNT_W-1:0] count_next;
    rtc_mode_t        mode_reg;
    logic             flag_reg;
    logic             overrun_reg;
    logic             ie_reg;

    logic             bus_cycle;
    logic             is_iot;
    logic             is_caf;
    rtc_fn_t          fn;
    logic [CNT_W-1:0] ac_cnt;
    logic [11:0]      count_ext;
    logic             count_tick;
    logic             overflow;
    logic             shot_done;

    assign bus_cycle = (state == ST_F1) && !UF;
    assign is_iot    = bus_cycle && (instruction[OP_MSB:OP_LSB] == OP_IOT)
                       && (instruction[DEV_MSB:DEV_LSB] == DEV_CODE);
    assign is_caf    = (bus_cycle && (instruction == CAF_INSN)) || clear;
    assign fn        = rtc_fn_t'(instruction[FN_MSB:FN_LSB]);
    assign ac_cnt    = ac[12-CNT_W:11];
    assign count_ext = 12'(count_reg);

    // A buffer load in the same cycle swallows the tick entirely.
    assign count_tick = tick && !(is_iot && fn == FN_CLLB);

    always_comb begin
        count_next = count_reg;
        overflow   = 1'b0;
        shot_done  = 1'b0;
        if (count_tick) begin
            case (mode_reg)
                MODE_FREE: begin
                    count_next = count_reg + 1'b1;
                    overflow   = &count_reg;
                end
                MODE_RELOAD: begin
                    if (&count_reg) begin
                        count_next = buffer_reg;
                        overflow   = 1'b1;
                    end else begin
                        count_next = count_reg + 1'b1;
                    end
                end
                MODE_SINGLE: begin
                    if (&count_reg) begin
                        count_next = '0;
                        overflow   = 1'b1;
                        shot_done  = 1'b1;
                    end else begin
                        count_next = count_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg   <= '0;
            buffer_reg  <= '0;
            mode_reg    <= MODE_STOP;
            flag_reg    <= 1'b0;
            overrun_reg <= 1'b0;
            ie_reg      <= 1'b1;
            ac_out      <= '0;
            ac_load     <= 1'b0;
            ac_clear    <= 1'b0;
            skip        <= 1'b0;
            interrupt   <= 1'b0;
        end else begin
            ac_out    <= '0;
            ac_load   <= 1'b0;
            ac_clear  <= 1'b0;
            interrupt <= flag_reg & ie_reg;
            if (bus_cycle) begin
                skip <= 1'b0;
            end

            count_reg <= count_next;
            if (overflow) begin
                flag_reg <= 1'b1;
                if (flag_reg) begin
                    overrun_reg <= 1'b1;
                end
            end
            if (shot_done) begin
                mode_reg <= MODE_STOP;
            end

            // IOT effects are applied after the counting update so they take priority,
            // except that an overflow keeps the flag set against CLSK.
            if (is_iot) begin
                case (fn)
                    FN_CLSK: begin
                        skip <= flag_reg;
                        if (!overflow) begin
                            flag_reg <= 1'b0;
                        end
                    end
                    FN_CLLB: begin
                        buffer_reg <= ac_cnt;
                        count_reg  <= ac_cnt;
                        ac_clear   <= 1'b1;
                    end
                    FN_CLRC: begin
                        ac_out  <= count_ext;
                        ac_load <= 1'b1;
                    end
                    FN_CLEI: ie_reg <= 1'b1;
                    FN_CLED: ie_reg <= 1'b0;
                    FN_CLMD: begin
                        mode_reg    <= rtc_mode_t'(ac[10:11]);
                        overrun_reg <= 1'b0;
                        ac_clear    <= 1'b1;
                    end
                    FN_CLRS: begin
                        ac_out  <= {overrun_reg, ie_reg, flag_reg, 7'b0, mode_reg};
                        ac_load <= 1'b1;
                    end
                    default: ;
                endcase
            end

            if (is_caf) begin
                flag_reg    <= 1'b0;
                overrun_reg <= 1'b0;
                mode_reg    <= MODE_STOP;
                ie_reg      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dk8ep_clock.sv
// Bench for dk8ep_clock (CNT_W=4, CLK_DIV=4): constant vector table, directed
// multi-cycle sequences and random IOT traffic checked against a behavioural model.
module tb_dk8ep_clock;
    import pdp8_pkg::*;

    localparam int         CNT_W = 4;
    localparam int         DIV   = 4;
    localparam int         MAXV  = (1 << CNT_W) - 1;
    localparam logic [5:0] DEV   = 6'o13;

    logic        clk;
    logic        reset;
    logic [0:11] instruction;
    logic [4:0]  state;
    logic        clear;
    logic        UF;
    logic [0:11] ac;
    logic        ext_tick;
    logic [0:11] ac_out;
    logic        ac_load;
    logic        ac_clear;
    logic        skip;
    logic        interrupt;

    dk8ep_clock #(
        .CNT_W    (CNT_W),
        .CLK_DIV  (DIV),
        .DEV_CODE (DEV)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .state       (state),
        .clear       (clear),
        .UF          (UF),
        .ac          (ac),
        .ext_tick    (ext_tick),
        .ac_out      (ac_out),
        .ac_load     (ac_load),
        .ac_clear    (ac_clear),
        .skip        (skip),
        .interrupt   (interrupt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_total = 0;
    int n_pass  = 0;

    // Behavioural model state
    int m_cnt, m_buf, m_mode, m_edges, m_out;
    bit m_flag, m_ovr, m_ie, m_int, m_skip, m_load, m_clr;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", nm, got, exp);
    endtask

    function automatic logic [31:0] dut_vec();
        return {16'h0, ac_out, ac_load, ac_clear, skip, interrupt};
    endfunction

    function automatic logic [31:0] model_vec();
        logic [11:0] o;
        o = 12'(m_out);
        return {16'h0, o, m_load, m_clr, m_skip, m_int};
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_buf = 0; m_mode = 0; m_edges = 0; m_out = 0;
        m_flag = 0; m_ovr = 0; m_ie = 1; m_int = 0; m_skip = 0; m_load = 0; m_clr = 0;
    endtask

    // One rising edge of the clock, applied to the rules of the device.
    task automatic model_edge();
        bit bus, iot, caf, tick, lost, ovf;
        int fnv, acv;
        int n_cnt, n_buf, n_mode, n_out;
        bit n_flag, n_ovr, n_ie, n_skip, n_load, n_clr;
        bus  = (state == ST_F1) && !UF;
        iot  = bus && (instruction[0:2] == 3'o6) && (instruction[3:8] == DEV);
        caf  = (bus && instruction == 12'o6007) || clear;
        fnv  = int'(instruction[9:11]);
        acv  = int'(ac);
        tick = (m_edges % DIV) == DIV - 1;
        m_edges++;
        lost = iot && fnv == 2;
        n_cnt = m_cnt; n_buf = m_buf; n_mode = m_mode; n_flag = m_flag; n_ovr = m_ovr; n_ie = m_ie;
        n_skip = bus ? 1'b0 : m_skip;
        n_out = 0; n_load = 0; n_clr = 0; ovf = 0;
        if (tick && !lost && m_mode != 0) begin
            if (m_cnt == MAXV) begin
                ovf = 1;
                if (m_mode == 2) n_cnt = m_buf;
                else n_cnt = 0;
                if (m_mode == 3) n_mode = 0;
            end else begin
                n_cnt = m_cnt + 1;
            end
        end
        if (ovf) begin
            if (m_flag) n_ovr = 1;
            n_flag = 1;
        end
        if (iot) begin
            case (fnv)
                1: begin n_skip = m_flag; if (!ovf) n_flag = 0; end
                2: begin n_buf = acv % (MAXV + 1); n_cnt = n_buf; n_clr = 1; end
                3: begin n_out = m_cnt; n_load = 1; end
                4: n_ie = 1;
                5: n_ie = 0;
                6: begin n_mode = acv % 4; n_ovr = 0; n_clr = 1; end
                7: begin n_out = m_ovr * 2048 + m_ie * 1024 + m_flag * 512 + m_mode; n_load = 1; end
                default: ;
            endcase
        end
        if (caf) begin
            n_flag = 0; n_ovr = 0; n_mode = 0; n_ie = 1;
        end
        m_int = m_flag && m_ie;
        m_cnt = n_cnt; m_buf = n_buf; m_mode = n_mode; m_flag = n_flag; m_ovr = n_ovr; m_ie = n_ie;
        m_skip = n_skip; m_out = n_out; m_load = n_load; m_clr = n_clr;
    endtask

    task automatic step(input logic [0:11] i, input logic [4:0] s, input logic u,
                        input logic [0:11] a, input logic c);
        instruction = i; state = s; UF = u; ac = a; clear = c;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("model", dut_vec(), model_vec());
    endtask

    function automatic logic [0:11] mk_iot(input logic [5:0] dev, input rtc_fn_t f);
        logic [0:11] r;
        r = {3'o6, dev, f};
        return r;
    endfunction

    task automatic iot_step(input rtc_fn_t f, input logic [0:11] a);
        step(mk_iot(DEV, f), ST_F1, 1'b0, a, 1'b0);
    endtask

    task automatic idle();
        step(12'o0000, ST_F0, 1'b0, 12'o0000, 1'b0);
    endtask

    task automatic idle_n(input int n);
        for (int k = 0; k < n; k++) idle();
    endtask

    // Advance until the next edge is a counting tick with the counter at all-ones.
    task automatic wait_pre_overflow(input string nm);
        bit found;
        found = 0;
        for (int k = 0; k < 200; k++) begin
            if ((m_edges % DIV) == DIV - 1 && m_mode != 0 && m_cnt == MAXV) begin
                found = 1;
                break;
            end
            idle();
        end
        n_total++;
        if (found) n_pass++;
        else $display("FAIL %s: overflow not reached in bound got 0 required 1", nm);
    endtask

    task automatic do_reset();
        reset = 1'b0; instruction = '0; state = ST_F0; clear = 1'b0; UF = 1'b0; ac = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", dut_vec(), 32'h0);
        reset = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [8*12-1:0] name;
        logic [0:11]     insn;
        logic [4:0]      st;
        logic            uf;
        logic [0:11]     acv;
        logic [11:0]     e_out;
        logic            e_load;
        logic            e_clr;
        logic            e_skip;
    } vec_t;

    localparam int NV = 17;
    vec_t tbl [NV];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] cnt_after_caf;
        ext_tick = 1'b0;

        tbl[0]  = '{"clrs_rst",  mk_iot(DEV, FN_CLRS), ST_F1, 1'b0, 12'o0000, 12'o2000, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{"cllb_5",    mk_iot(DEV, FN_CLLB), ST_F1, 1'b0, 12'o0005, 12'o0000, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{"clrc_5",    mk_iot(DEV, FN_CLRC), ST_F1, 1'b0, 12'o0000, 12'o0005, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{"cled",      mk_iot(DEV, FN_CLED), ST_F1, 1'b0, 12'o0000, 12'o0000, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{"clrs_ie0",  mk_iot(DEV, FN_CLRS), ST_F1, 1'b0, 12'o0000, 12'o0000, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{"clei",      mk_iot(DEV, FN_CLEI), ST_F1, 1'b0, 12'o0000, 12'o0000, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{"clrs_ie1",  mk_iot(DEV, FN_CLRS), ST_F1, 1'b0, 12'o0000, 12'o2000, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{"clsk_noflg",mk_iot(DEV, FN_CLSK), ST_F1, 1'b0, 12'o0000, 12'o0000, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{"clrc_uf",   mk_iot(DEV, FN_CLRC), ST_F1, 1'b1, 12'o0000, 12'o0000, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{"clrc_f0",   mk_iot(DEV, FN_CLRC), ST_F0, 1'b0, 12'o0000, 12'o0000, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{"clrc_odev", mk_iot(6'o14, FN_CLRC), ST_F1, 1'b0, 12'o0000, 12'o0000, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{"cllb_7777", mk_iot(DEV, FN_CLLB), ST_F1, 1'b0, 12'o7777, 12'o0000, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{"clrc_17",   mk_iot(DEV, FN_CLRC), ST_F1, 1'b0, 12'o0000, 12'o0017, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{"clmd_0",    mk_iot(DEV, FN_CLMD), ST_F1, 1'b0, 12'o0000, 12'o0000, 1'b0, 1'b1, 1'b0};
        tbl[14] = '{"clrs_md0",  mk_iot(DEV, FN_CLRS), ST_F1, 1'b0, 12'o0000, 12'o2000, 1'b1, 1'b0, 1'b0};
        tbl[15] = '{"caf",       12'o6007,             ST_F1, 1'b0, 12'o0000, 12'o0000, 1'b0, 1'b0, 1'b0};
        tbl[16] = '{"clrc_keep", mk_iot(DEV, FN_CLRC), ST_F1, 1'b0, 12'o0000, 12'o0017, 1'b1, 1'b0, 1'b0};

        do_reset();
        for (int k = 0; k < NV; k++) begin
            step(tbl[k].insn, tbl[k].st, tbl[k].uf, tbl[k].acv, 1'b0);
            check($sformatf("%0s", tbl[k].name), dut_vec(),
                  {16'h0, tbl[k].e_out, tbl[k].e_load, tbl[k].e_clr, tbl[k].e_skip, 1'b0});
        end

        // Mode 1 from 4'hE: overflow on the second tick (edge 7), interrupt one cycle later.
        do_reset();
        iot_step(FN_CLLB, 12'o0016);
        iot_step(FN_CLMD, 12'o0001);
        idle_n(6);
        check("m1_int_before", {31'h0, interrupt}, 32'h0);
        idle();
        check("m1_int_after", {31'h0, interrupt}, 32'h1);
        iot_step(FN_CLRS, 12'o0000);
        check("m1_clrs", {20'h0, ac_out}, 32'o3001);
        iot_step(FN_CLSK, 12'o0000);
        check("m1_clsk1", {31'h0, skip}, 32'h1);
        iot_step(FN_CLSK, 12'o0000);
        check("m1_clsk2", {31'h0, skip}, 32'h0);

        // Mode 2 reload from 4'hC: one overflow every four ticks.
        iot_step(FN_CLLB, 12'o0014);
        iot_step(FN_CLMD, 12'o0002);
        wait_pre_overflow("m2_wait");
        idle();
        iot_step(FN_CLRC, 12'o0000);
        check("m2_clrc", {20'h0, ac_out}, 32'o0014);
        iot_step(FN_CLSK, 12'o0000);
        check("m2_clsk", {31'h0, skip}, 32'h1);
        idle_n(12);
        iot_step(FN_CLRS, 12'o0000);
        check("m2_noflag", {20'h0, ac_out}, 32'o2002);
        idle();
        iot_step(FN_CLRS, 12'o0000);
        check("m2_flag4", {20'h0, ac_out}, 32'o3002);

        // Mode 3 single shot, then skip behaviour including UF=1.
        iot_step(FN_CLSK, 12'o0000);
        iot_step(FN_CLLB, 12'o0016);
        iot_step(FN_CLMD, 12'o0003);
        wait_pre_overflow("m3_wait");
        idle();
        iot_step(FN_CLRS, 12'o0000);
        check("m3_clrs", {20'h0, ac_out}, 32'o3000);
        idle_n(80);
        iot_step(FN_CLRC, 12'o0000);
        check("m3_cnt0", {20'h0, ac_out}, 32'o0000);
        step(mk_iot(DEV, FN_CLSK), ST_F1, 1'b1, 12'o0000, 1'b0);
        check("uf_clsk", {31'h0, skip}, 32'h0);
        iot_step(FN_CLRS, 12'o0000);
        check("uf_keepflag", {20'h0, ac_out}, 32'o3000);
        iot_step(FN_CLSK, 12'o0000);
        check("m3_clsk1", {31'h0, skip}, 32'h1);
        iot_step(FN_CLSK, 12'o0000);
        check("m3_clsk2", {31'h0, skip}, 32'h0);

        // Overrun, CLMD clearing it, and CLSK coincident with an overflow.
        iot_step(FN_CLLB, 12'o0016);
        iot_step(FN_CLMD, 12'o0001);
        idle_n(200);
        iot_step(FN_CLRS, 12'o0000);
        check("ovr_set", {20'h0, ac_out}, 32'o7001);
        iot_step(FN_CLMD, 12'o0001);
        iot_step(FN_CLRS, 12'o0000);
        check("ovr_clr", {20'h0, ac_out}, 32'o3001);
        wait_pre_overflow("clsk_ovf_wait");
        iot_step(FN_CLSK, 12'o0000);
        check("clsk_ovf_skip", {31'h0, skip}, 32'h1);
        iot_step(FN_CLRS, 12'o0000);
        check("clsk_ovf_flag", {20'h0, ac_out}, 32'o7001);

        // Interrupt disabled across an overflow, then CAF.
        iot_step(FN_CLSK, 12'o0000);
        iot_step(FN_CLED, 12'o0000);
        wait_pre_overflow("cled_wait");
        idle_n(3);
        check("cled_noint", {31'h0, interrupt}, 32'h0);
        iot_step(FN_CLRS, 12'o0000);
        check("cled_clrs", {20'h0, ac_out}, 32'o5001);
        step(12'o6007, ST_F1, 1'b0, 12'o0000, 1'b0);
        cnt_after_caf = 12'(m_cnt);
        iot_step(FN_CLRS, 12'o0000);
        check("caf_clrs", {20'h0, ac_out}, 32'o2000);
        iot_step(FN_CLRC, 12'o0000);
        check("caf_cnt", {20'h0, ac_out}, {20'h0, cnt_after_caf});

        // Asynchronous reset in the middle of a cycle.
        iot_step(FN_CLMD, 12'o0001);
        iot_step(FN_CLRS, 12'o0000);
        #2 reset = 1'b0;
        #1 check("async_reset", dut_vec(), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
        iot_step(FN_CLRS, 12'o0000);
        check("post_rst_clrs", {20'h0, ac_out}, 32'o2000);
        iot_step(FN_CLRC, 12'o0000);
        check("post_rst_clrc", {20'h0, ac_out}, 32'o0000);

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            int r;
            logic [0:11] a;
            r = $urandom_range(0, 99);
            a = 12'($urandom_range(0, 4095));
            if (r < 70) begin
                step(mk_iot(DEV, rtc_fn_t'($urandom_range(0, 7))),
                     ($urandom_range(0, 9) == 0) ? ST_F0 : ST_F1,
                     ($urandom_range(0, 9) == 0), a, 1'b0);
            end else if (r < 74) begin
                step(12'o6007, ST_F1, 1'b0, a, 1'b0);
            end else if (r < 77) begin
                step(12'o0000, ST_F0, 1'b0, a, 1'b1);
            end else if (r < 82) begin
                step(mk_iot(6'o14, rtc_fn_t'($urandom_range(0, 7))), ST_F1, 1'b0, a, 1'b0);
            end else begin
                idle();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
